// File: rtl/pipe_front_regs.sv
// Front-end pipeline registers for the 5-stage RV32 core: PC, IF/ID, ID/EX,
// driven by hazard-unit stall/flush commands, plus two saturating event counters.
module pipe_front_regs #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     CTRL_W   = 10,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_f,
    input  logic              stall_d,
    input  logic              flush_d,
    input  logic              flush_e,
    input  logic              pcsrc_e,
    input  logic [XLEN-1:0]   pc_target_e,
    input  logic [31:0]       instr_f,
    output logic [XLEN-1:0]   pc_f,
    output logic [31:0]       instr_d,
    output logic [XLEN-1:0]   pc_d,
    output logic [XLEN-1:0]   pc_plus4_d,
    output logic              valid_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [XLEN-1:0]   rd1_d,
    input  logic [XLEN-1:0]   rd2_d,
    input  logic [XLEN-1:0]   immext_d,
    input  logic [4:0]        rs1_d,
    input  logic [4:0]        rs2_d,
    input  logic [4:0]        rd_d,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [XLEN-1:0]   immext_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pc_plus4_e,
    output logic [4:0]        rs1_e,
    output logic [4:0]        rs2_e,
    output logic [4:0]        rd_e,
    output logic              valid_e,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  load_stall_cnt,
    output logic [CNT_W-1:0]  redirect_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] pc_plus4_f;
    logic            load_stall_evt;

    assign pc_plus4_f     = pc_f + XLEN'(4);
    assign load_stall_evt = stall_d && !flush_d;

    // A redirect overrides stall_f.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f <= RESET_PC;
        end else if (pcsrc_e) begin
            pc_f <= pc_target_e;
        end else if (!stall_f) begin
            pc_f <= pc_plus4_f;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_d    <= NOP;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (flush_d) begin
            instr_d    <= NOP;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (!stall_d) begin
            instr_d    <= instr_f;
            pc_d       <= pc_f;
            pc_plus4_d <= pc_plus4_f;
            valid_d    <= 1'b1;
        end
    end

    // ID/EX never holds; a flush inserts an all-zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush_e) begin
            ctrl_e     <= '0;
            rd1_e      <= '0;
            rd2_e      <= '0;
            immext_e   <= '0;
            pc_e       <= '0;
            pc_plus4_e <= '0;
            rs1_e      <= '0;
            rs2_e      <= '0;
            rd_e       <= '0;
            valid_e    <= 1'b0;
        end else begin
            ctrl_e     <= ctrl_d;
            rd1_e      <= rd1_d;
            rd2_e      <= rd2_d;
            immext_e   <= immext_d;
            pc_e       <= pc_d;
            pc_plus4_e <= pc_plus4_d;
            rs1_e      <= rs1_d;
            rs2_e      <= rs2_d;
            rd_e       <= rd_d;
            valid_e    <= valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_stall_cnt <= '0;
            redirect_cnt   <= '0;
        end else if (cnt_clr) begin
            load_stall_cnt <= '0;
            redirect_cnt   <= '0;
        end else begin
            if (load_stall_evt && load_stall_cnt != '1) begin
                load_stall_cnt <= load_stall_cnt + CNT_W'(1);
            end
            if (pcsrc_e && redirect_cnt != '1) begin
                redirect_cnt <= redirect_cnt + CNT_W'(1);
            end
        end
    end

endmodule
